// File: rtl/spike_direction_arbiter.sv
// Windowed spike-count arbiter: counts per-direction spikes over WIN_LEN clk_en ticks
// and emits a one-hot winning direction {W,E,S,N} once per window.
module spike_direction_arbiter #(
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       enable_i,
  input  logic [3:0] spike_i,
  output logic [3:0] ch_fire_o,
  output logic       fire_valid_o,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(WIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] THR       = CNT_W'(THRESH);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DECIDE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tick_cnt, tick_nxt;
  logic [CNT_W-1:0] cnt      [4];
  logic [CNT_W-1:0] cnt_nxt  [4];
  logic [CNT_W-1:0] snap     [4];
  logic [CNT_W-1:0] snap_nxt [4];
  logic [CNT_W-1:0] cnt_inc  [4];
  logic [CNT_W-1:0] snap_max;
  logic [3:0]       cand;
  logic [3:0]       pick;
  logic [3:0]       decision;
  logic [3:0]       fire_nxt;
  logic             valid_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    for (int unsigned d = 0; d < 4; d++) begin
      cnt_inc[d] = sat_inc(cnt[d], spike_i[d]);
    end
  end

  // Winner selection on the frozen snapshot; an already-asserted direction wins ties.
  always_comb begin
    snap_max = '0;
    for (int unsigned d = 0; d < 4; d++) begin
      if (snap[d] > snap_max) snap_max = snap[d];
    end
    cand = '0;
    for (int unsigned d = 0; d < 4; d++) begin
      cand[d] = (snap[d] >= THR) && (snap[d] == snap_max);
    end
    casez (cand)
      4'b???1: pick = 4'b0001;
      4'b??10: pick = 4'b0010;
      4'b?100: pick = 4'b0100;
      4'b1000: pick = 4'b1000;
      default: pick = 4'b0000;
    endcase
    decision = (|(ch_fire_o & cand)) ? ch_fire_o : pick;
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    cnt_nxt   = cnt;
    snap_nxt  = snap;
    fire_nxt  = ch_fire_o;
    valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        tick_nxt = '0;
        for (int unsigned d = 0; d < 4; d++) begin
          cnt_nxt[d]  = '0;
          snap_nxt[d] = '0;
        end
        fire_nxt = '0;
        if (enable_i) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (!enable_i) begin
          state_nxt = IDLE;
          tick_nxt  = '0;
          for (int unsigned d = 0; d < 4; d++) begin
            cnt_nxt[d]  = '0;
            snap_nxt[d] = '0;
          end
          fire_nxt = '0;
        end else if (clk_en) begin
          if (tick_cnt == LAST_TICK) begin
            // Final tick's spikes go straight into the snapshot, counters restart.
            snap_nxt  = cnt_inc;
            tick_nxt  = '0;
            for (int unsigned d = 0; d < 4; d++) cnt_nxt[d] = '0;
            state_nxt = DECIDE;
          end else begin
            cnt_nxt  = cnt_inc;
            tick_nxt = tick_cnt + CNT_W'(1);
          end
        end
      end
      DECIDE: begin
        fire_nxt  = decision;
        valid_nxt = 1'b1;
        if (enable_i) begin
          state_nxt = ACCUM;
          // This cycle may already be tick 0 of the next window.
          if (clk_en) begin
            cnt_nxt  = cnt_inc;
            tick_nxt = tick_cnt + CNT_W'(1);
          end
        end else begin
          state_nxt = IDLE;
          tick_nxt  = '0;
          for (int unsigned d = 0; d < 4; d++) cnt_nxt[d] = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      for (int unsigned d = 0; d < 4; d++) begin
        cnt[d]  <= '0;
        snap[d] <= '0;
      end
      ch_fire_o    <= '0;
      fire_valid_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      tick_cnt     <= tick_nxt;
      cnt          <= cnt_nxt;
      snap         <= snap_nxt;
      ch_fire_o    <= fire_nxt;
      fire_valid_o <= valid_nxt;
    end
  end

  assign busy_o = (state == ACCUM) || (state == DECIDE);

endmodule

// File: tb/tb_spike_direction_arbiter.sv
// Scoreboard bench for spike_direction_arbiter: a tick-stream reference model predicts
// each window's decision and its cycle; a monitor compares on every fire_valid_o pulse.
module tb_spike_direction_arbiter;

  localparam int WIN = 8;
  localparam int THR = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_en;
  logic       enable_i;
  logic [3:0] spike_i;
  logic [3:0] ch_fire_o;
  logic       fire_valid_o;
  logic       busy_o;

  logic       enable_b;
  logic [3:0] ch_fire_b;
  logic       fire_valid_b;
  logic       busy_b;

  spike_direction_arbiter #(.WIN_LEN(WIN), .THRESH(THR)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .enable_i     (enable_i),
    .spike_i      (spike_i),
    .ch_fire_o    (ch_fire_o),
    .fire_valid_o (fire_valid_o),
    .busy_o       (busy_o)
  );

  spike_direction_arbiter #(.WIN_LEN(255), .THRESH(255)) u_big (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (1'b1),
    .enable_i     (enable_b),
    .spike_i      (4'hF),
    .ch_fire_o    (ch_fire_b),
    .fire_valid_o (fire_valid_b),
    .busy_o       (busy_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: a window is simply the next WIN sampled ticks while running.
  logic [3:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [3:0] win_ticks[$];
  bit         running;
  bit         last_done;
  logic [3:0] prev;

  function automatic logic [3:0] model_decide();
    int c[4];
    int mx;
    logic [3:0] cands;
    c = '{0, 0, 0, 0};
    foreach (win_ticks[i]) begin
      for (int d = 0; d < 4; d++) c[d] += int'(win_ticks[i][d]);
    end
    mx = 0;
    for (int d = 0; d < 4; d++) if (c[d] > mx) mx = c[d];
    cands = '0;
    for (int d = 0; d < 4; d++) cands[d] = (c[d] >= THR) && (c[d] == mx);
    if ((prev & cands) != 4'b0000) return prev;
    for (int d = 0; d < 4; d++) if (cands[d]) return 4'(1 << d);
    return 4'b0000;
  endfunction

  task automatic drive(input bit en, input bit ce, input logic [3:0] sp);
    logic [3:0] dec;
    @(negedge clk);
    enable_i  = en;
    clk_en    = ce;
    spike_i   = sp;
    last_done = 1'b0;
    if (!running) begin
      if (en) running = 1'b1;
    end else if (!en) begin
      running = 1'b0;
      prev    = 4'b0000;
      win_ticks.delete();
    end else if (ce) begin
      win_ticks.push_back(sp);
      if (win_ticks.size() == WIN) begin
        dec = model_decide();
        exp_q.push_back(dec);
        exp_cyc_q.push_back(cyc + 2);
        prev      = dec;
        last_done = 1'b1;
        win_ticks.delete();
      end
    end
  endtask

  task automatic win8(input logic [31:0] p);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, p[i*4 +: 4]);
  endtask

  always @(negedge clk) begin : monitor
    logic [3:0] e;
    int         c;
    if (rst_n && fire_valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_fire_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("ch_fire_o", int'(ch_fire_o), int'(e));
        check("fire_latency", cyc, c);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  t0;
    bit  found;
    logic [3:0] bias;
    rst_n     = 1'b0;
    enable_i  = 1'b0;
    clk_en    = 1'b0;
    spike_i   = 4'b0000;
    enable_b  = 1'b0;
    running   = 1'b0;
    last_done = 1'b0;
    prev      = 4'b0000;
    bias      = 4'hF;
    #1;
    check("reset_ch_fire", int'(ch_fire_o), 0);
    check("reset_fire_valid", int'(fire_valid_o), 0);
    check("reset_busy", int'(busy_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Long window with every direction spiking each tick: counts reach 255 without wrapping.
    @(negedge clk);
    enable_b = 1'b1;
    t0       = cyc;
    found    = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fire_valid_b) begin
        found = 1'b1;
        break;
      end
    end
    check("big_fire_seen", int'(found), 1);
    if (found) begin
      check("big_ch_fire", int'(ch_fire_b), 1);
      check("big_latency", cyc - t0, 257);
    end
    enable_b = 1'b0;

    drive(1'b1, 1'b1, 4'hF);
    check("busy_idle_before_start", int'(busy_o), 0);
    win8(32'h4004_0444);
    check("busy_accum", int'(busy_o), 1);
    win8(32'h4141_4141);
    win8(32'h0000_4321);
    win8(32'h4141_4141);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 4'hF);
      drive(1'b1, 1'b0, 4'hF);
      drive(1'b1, 1'b1, 4'hF);
    end

    repeat (5) drive(1'b1, 1'b1, 4'b0001);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_ch_fire", int'(ch_fire_o), 0);
    check("midreset_fire_valid", int'(fire_valid_o), 0);
    check("midreset_busy", int'(busy_o), 0);
    running = 1'b0;
    prev    = 4'b0000;
    win_ticks.delete();
    @(negedge clk);
    enable_i = 1'b0;
    rst_n    = 1'b1;
    drive(1'b1, 1'b0, 4'b0000);
    win8(32'h1001_0010);

    win8(32'h8880_0000);
    win8(32'h0020_0202);

    repeat (5) drive(1'b1, 1'b1, 4'b0000);
    drive(1'b0, 1'b1, 4'hF);
    drive(1'b0, 1'b0, 4'b0000);
    check("disable_ch_fire", int'(ch_fire_o), 0);
    check("disable_busy", int'(busy_o), 0);
    repeat (3) drive(1'b0, 1'b0, 4'b0000);

    drive(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 800; i++) begin
      if (i % 16 == 0) bias = 4'($urandom);
      if (!last_done && $urandom_range(0, 99) == 0) begin
        drive(1'b0, 1'($urandom), 4'($urandom));
        drive(1'b0, 1'b0, 4'b0000);
        check("rand_disable_ch_fire", int'(ch_fire_o), 0);
        check("rand_disable_busy", int'(busy_o), 0);
        drive(1'b1, 1'($urandom), 4'($urandom));
      end else begin
        drive(1'b1, $urandom_range(0, 3) != 0, 4'($urandom) & (bias | 4'($urandom)));
      end
    end

    repeat (2) drive(1'b1, 1'b0, 4'b0000);
    drive(1'b0, 1'b0, 4'b0000);
    repeat (4) drive(1'b0, 1'b0, 4'b0000);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spike_direction_arbiter.md
Name: spike_direction_arbiter

Overview:
- Upstream stage of the 4-direction motor decoder.
- Counts per-direction spike events from the SNN output layer over a fixed window of clk_en ticks. Selects one winning direction per window.
- Drives a one-hot ch_fire_o word (bit0=N, bit1=S, bit2=E, bit3=W), held stable between decisions.
- Bit mapping matches the decoder's ch_fire_i exactly.

Parameters:
- WIN_LEN, 16: window length in clk_en ticks; legal range 2..255.
- THRESH, 4: minimum spike count a direction needs to fire; legal range 1..WIN_LEN.
- CNT_W: localparam, $clog2(WIN_LEN+1); per-direction counter width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- clk_en  input  1  tick enable; spike sampling and window advance happen only when it is 1.
- enable_i  input  1  arbiter run enable; 0 forces IDLE.
- spike_i  input  4  per-direction spike flags for the current tick, {W,E,S,N}.
- ch_fire_o  output  4  one-hot winning direction, or 4'b0000 for no fire; registered.
- fire_valid_o  output  1  one-clk pulse when ch_fire_o has just been updated.
- busy_o  output  1  1 while in ACCUM or DECIDE.

Behaviour:
- Reset (async, rst_n=0) clears:
  - state to IDLE
  - tick_cnt, the four cnt[d] and the four snap[d] to 0
  - ch_fire_o to 0, fire_valid_o to 0, busy_o to 0
- States: IDLE, ACCUM, DECIDE. All state and output registers are clocked on posedge clk.
- IDLE:
  - Counters are held at 0. ch_fire_o is forced to 0.
  - enable_i=1 moves to ACCUM on the next clk, regardless of clk_en.
- ACCUM, on each clk_en=1 cycle:
  - For every d with spike_i[d]=1, cnt[d] increments.
  - cnt[d] saturates at 2^CNT_W-1 and never wraps.
  - tick_cnt increments.
- Last window tick (ACCUM, clk_en=1, tick_cnt==WIN_LEN-1):
  - snap[d] <= cnt[d] + spike_i[d], saturating, so the final tick's spikes are included.
  - cnt[d] and tick_cnt clear to 0; state moves to DECIDE.
- ACCUM with clk_en=0: no change of any register.
- DECIDE: lasts exactly one clk, independent of clk_en. In that clk:
  - Form the candidate set: directions with snap[d] >= THRESH and snap[d] == max over all d of snap.
  - Empty candidate set: ch_fire_o <= 0.
  - Currently asserted direction is a candidate: keep it (tie hysteresis).
  - Otherwise pick the lowest-index candidate (priority N>S>E>W).
  - fire_valid_o <= 1 for that one clk, even when the value is unchanged.
  - Go to ACCUM if enable_i=1, else IDLE.
- Spikes arriving while in DECIDE are counted into the next window.
  - cnt[d] was cleared on the last tick, so DECIDE counting is allowed if clk_en=1 (the next window's tick 0 may land in the DECIDE cycle).
  - Net effect: no tick is lost or double-counted across window boundaries.
- Latency: ch_fire_o and fire_valid_o change 1 clk after the edge that sampled the last window tick.
- enable_i deasserted during ACCUM:
  - Next clk goes to IDLE; cnt, tick_cnt and snap are cleared.
  - ch_fire_o <= 0, with no fire_valid_o pulse. The partial window is discarded.
- Re-enable always starts a fresh full window (tick_cnt=0).
- ch_fire_o is always one-hot or zero; it never has more than one bit set.
- busy_o is combinational from the state register: 1 in ACCUM or DECIDE, else 0.

Test Plan (WIN_LEN=8, THRESH=3):
- Reset mid-ACCUM with cnt N=5: assert rst_n=0 -> all outputs 0 immediately. After release and enable_i=1, the first decision occurs after 8 new ticks.
- Enable, clk_en=1 every cycle, spike_i=4'b0100 on 5 of 8 ticks, others 0 -> ch_fire_o=4'b0100 one clk after the 8th tick; fire_valid_o high exactly 1 clk.
- Counts N=2, S=2, E=1, W=0 (all below THRESH) -> ch_fire_o=4'b0000, fire_valid_o pulses.
- Tie handling:
  - Previous window won by E=4'b0100; new counts N=4, E=4 -> ch_fire_o stays 4'b0100 (hysteresis).
  - Same counts with previous output 0 -> 4'b0001.
- Saturation and clk_en gating: spike_i=4'b1111 every tick with clk_en=1 only every 3rd clk -> window spans 24 clks; all counts equal 8 -> ch_fire_o=4'b0001.
  - Extra check with WIN_LEN=255: every count saturates at 255 with no wrap.
- Boundary and disable:
  - Spike on the last tick plus a spike coinciding with DECIDE -> the last-tick spike lands in the current window, the DECIDE-cycle spike lands in the next. Check snap/cnt values.
  - enable_i=0 at tick 5 -> ch_fire_o=0, no fire_valid_o, busy_o=0 next clk.
